// File: rtl/codificador_teclado.sv
// codificador_teclado
// Scanning encoder for a 4x4 active-low matrix keypad. One row is driven low
// at a time; the columns are synchronized, the first key seen is debounced on
// press and on release, and an accepted press produces a 4-bit key code with a
// one-cycle valid strobe. The code drives the 4-bit-to-7-segment decoder.
//
// Parameters:
//   SCAN_DIV  cycles each row is held low before it is sampled (>= 4)
//   DEBOUNCE  consecutive stable samples to accept a press or a release (>= 2)
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  synchronous, active-high reset
//   col      in   4  keypad columns, active-low, asynchronous to clk
//   row      out  4  keypad row drive, active-low, exactly one bit low
//   code     out  4  last accepted key, 4*row_index + col_index
//   valid    out  1  one-cycle strobe marking a new code
//   pressed  out  1  high from accepted press until accepted release
module codificador_teclado #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] code,
  output logic       valid,
  output logic       pressed
);

  // One shared counter serves the scan dwell and both debounce phases, so it
  // is sized for the larger of the two terminal counts.
  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    WAIT_REL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       row_idx, row_idx_n;
  logic [1:0]       col_idx, col_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       row_n;
  logic [3:0]       code_n;
  logic             valid_n;
  logic             pressed_n;

  logic [3:0]       col_meta;
  logic [3:0]       cs;
  logic [1:0]       low_col;
  logic             watched_low;

  // Two-flop synchronizer for the asynchronous column inputs. Reset parks it
  // at "no key" so a stale low cannot leak across a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'hF;
      cs       <= 4'hF;
    end else begin
      col_meta <= col;
      cs       <= col_meta;
    end
  end

  // Lowest-indexed low column wins when several keys share the active row.
  always_comb begin
    low_col = 2'd3;
    if (!cs[0])      low_col = 2'd0;
    else if (!cs[1]) low_col = 2'd1;
    else if (!cs[2]) low_col = 2'd2;
  end

  // Only the latched column is watched once a candidate key is chosen.
  assign watched_low = ~cs[col_idx];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      cnt     <= '0;
      row     <= 4'b1110;
      code    <= 4'h0;
      valid   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_n;
      row_idx <= row_idx_n;
      col_idx <= col_idx_n;
      cnt     <= cnt_n;
      row     <= row_n;
      code    <= code_n;
      valid   <= valid_n;
      pressed <= pressed_n;
    end
  end

  // Next-state logic. The row register is re-derived from the next row index
  // so the drive pins come straight from flops.
  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    col_idx_n = col_idx;
    cnt_n     = cnt;
    code_n    = code;
    valid_n   = 1'b0;
    pressed_n = pressed;

    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          if (cs != 4'hF) begin
            col_idx_n = low_col;
            state_n   = DEB_PRESS;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DEB_PRESS: begin
        if (watched_low) begin
          if (cnt == DEB_LAST) begin
            cnt_n     = '0;
            code_n    = {row_idx, col_idx};
            valid_n   = 1'b1;
            pressed_n = 1'b1;
            state_n   = WAIT_REL;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else begin
          // A bounce aborts the candidate; rescan the same row from scratch.
          cnt_n   = '0;
          state_n = SCAN;
        end
      end

      WAIT_REL: begin
        if (!watched_low) begin
          if (cnt == DEB_LAST) begin
            cnt_n     = '0;
            pressed_n = 1'b0;
            row_idx_n = row_idx + 2'd1;
            state_n   = SCAN;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = SCAN;
      end
    endcase

    row_n = ~(4'b0001 << row_idx_n);
  end

endmodule

// File: tb/tb_codificador_teclado.sv
// tb_codificador_teclado
// Directed bench for codificador_teclado with SCAN_DIV=4, DEBOUNCE=8.
// A behavioural keypad pulls col[c] low while key (r,c) is closed and row[r]
// is low. Expected values are hand-computed cycle indices counted in falling
// edges after reset release.
module tb_codificador_teclado;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] code;
  logic       valid;
  logic       pressed;

  // keys[4*r+c] set means key (r,c) is closed
  logic [15:0] keys;

  int n_checks;
  int n_fail;
  int cyc;
  int valid_count;
  int first_valid_cyc;
  int last_valid_cyc;
  int last_valid_code;
  int back_to_back;
  logic prev_valid;

  localparam logic [15:0] K_00 = 16'h0001;
  localparam logic [15:0] K_03 = 16'h0008;
  localparam logic [15:0] K_10 = 16'h0010;
  localparam logic [15:0] K_12 = 16'h0040;
  localparam logic [15:0] K_21 = 16'h0200;
  localparam logic [15:0] K_32 = 16'h4000;
  localparam logic [15:0] K_33 = 16'h8000;

  codificador_teclado #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .col    (col),
    .row    (row),
    .code   (code),
    .valid  (valid),
    .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Set the keypad state and run n cycles, recording every valid strobe.
  task automatic applyStimulus(input logic [15:0] k, input int n);
    keys = k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        valid_count++;
        if (valid_count == 1) first_valid_cyc = cyc;
        last_valid_cyc  = cyc;
        last_valid_code = int'(code);
        if (prev_valid) back_to_back++;
      end
      prev_valid = valid;
    end
  endtask

  task automatic resetDut();
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic releaseReset();
    rst             = 1'b0;
    cyc             = 0;
    valid_count     = 0;
    first_valid_cyc = -1;
    last_valid_cyc  = -1;
    last_valid_code = -1;
    prev_valid      = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    back_to_back = 0;
    rst          = 1'b1;
    keys         = '0;
    cyc          = 0;

    // Reset values and idle scan
    resetDut();
    checkOutput("rst_row", row, 4'b1110);
    checkOutput("rst_code", code, 4'h0);
    checkOutput("rst_valid", valid, 1'b0);
    checkOutput("rst_pressed", pressed, 1'b0);
    releaseReset();
    for (int i = 0; i < 20; i++) begin
      logic [3:0] exp_row;
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      checkOutput("idle_row", row, exp_row);
      checkOutput("idle_valid", valid, 1'b0);
      checkOutput("idle_pressed", pressed, 1'b0);
      checkOutput("idle_code", code, 4'h0);
      applyStimulus('0, 1);
    end

    // Clean press of (2,1)
    resetDut();
    releaseReset();
    applyStimulus(K_21, 40);
    checkOutput("clean_count", valid_count, 1);
    checkOutput("clean_valid_cyc", first_valid_cyc, 20);
    checkOutput("clean_code", last_valid_code, 9);
    checkOutput("clean_pressed", pressed, 1'b1);
    checkOutput("clean_row_held", row, 4'b1011);
    applyStimulus('0, 9);
    checkOutput("clean_pressed_hold", pressed, 1'b1);
    applyStimulus('0, 1);
    checkOutput("clean_pressed_fall", pressed, 1'b0);
    checkOutput("clean_next_row", row, 4'b0111);
    checkOutput("clean_code_kept", code, 4'h9);
    checkOutput("clean_count_after", valid_count, 1);

    // Bouncing (0,3), then steady
    resetDut();
    releaseReset();
    for (int ph = 0; ph < 10; ph++)
      applyStimulus((ph % 2 == 0) ? K_03 : 16'h0000, 3);
    checkOutput("bounce_no_valid", valid_count, 0);
    checkOutput("bounce_no_pressed", pressed, 1'b0);
    applyStimulus(K_03, 40);
    checkOutput("bounce_count", valid_count, 1);
    checkOutput("bounce_code", last_valid_code, 3);
    checkOutput("bounce_pressed", pressed, 1'b1);

    // Simultaneous keys in row 1, then a key in row 3 while (1,0) is held
    resetDut();
    releaseReset();
    applyStimulus(K_12 | K_10, 40);
    checkOutput("simul_count", valid_count, 1);
    checkOutput("simul_valid_cyc", first_valid_cyc, 16);
    checkOutput("simul_code", last_valid_code, 4);
    applyStimulus(K_10 | K_33, 30);
    checkOutput("simul_ignore_other", valid_count, 1);
    checkOutput("simul_row_held", row, 4'b1101);
    checkOutput("simul_still_pressed", pressed, 1'b1);
    applyStimulus(K_33, 40);
    checkOutput("simul_count2", valid_count, 2);
    checkOutput("simul_valid_cyc2", last_valid_cyc, 96);
    checkOutput("simul_code2", last_valid_code, 15);

    // Reset three cycles into debounce of (3,2)
    resetDut();
    releaseReset();
    applyStimulus(K_32, 18);
    rst = 1'b1;
    applyStimulus(K_32, 2);
    checkOutput("middeb_no_valid", valid_count, 0);
    checkOutput("middeb_row", row, 4'b1110);
    checkOutput("middeb_code", code, 4'h0);
    checkOutput("middeb_pressed", pressed, 1'b0);
    releaseReset();
    applyStimulus(K_32, 30);
    checkOutput("middeb_redetect_count", valid_count, 1);
    checkOutput("middeb_redetect_cyc", first_valid_cyc, 24);
    checkOutput("middeb_redetect_code", last_valid_code, 14);

    // Repeat key (0,0)
    resetDut();
    releaseReset();
    applyStimulus(K_00, 30);
    checkOutput("repeat_first_cyc", first_valid_cyc, 12);
    applyStimulus('0, 20);
    checkOutput("repeat_released", pressed, 1'b0);
    applyStimulus(K_00, 40);
    checkOutput("repeat_count", valid_count, 2);
    checkOutput("repeat_second_cyc", last_valid_cyc, 64);
    checkOutput("repeat_code", last_valid_code, 0);
    checkOutput("repeat_gap_ok", (last_valid_cyc - first_valid_cyc) >= 2 * DEBOUNCE, 1);

    checkOutput("no_back_to_back_valid", back_to_back, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
